// File: rtl/mb_rtu_frame_if.sv
// mb_rtu_frame_if: byte-in / register-write-out bundle.
// Ports: rx_valid/rx_data in, wr_*, frame_done, crc_err, frame_err, busy out.
interface mb_rtu_frame_if #(
  parameter int ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic              crc_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data,
    input  frame_done, crc_err, frame_err, busy
  );

  modport slave (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data,
    output frame_done, crc_err, frame_err, busy
  );
endinterface

// File: rtl/mb_rtu_frame.sv
// mb_rtu_frame: Modbus RTU slave frame engine (FC 0x06 / 0x10 writes).
// Ports: clk, rst (sync, high), bus (slave): rx bytes in,
//   register write stream, frame_done/crc_err/frame_err pulses, busy.
// Option: MB_BROADCAST_EN accepts station address 0x00.
module mb_rtu_frame #(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int TIMER_OUT = 10000,
  parameter int MAX_REGS  = 8,
  parameter int ADDR_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  mb_rtu_frame_if.slave bus
);
  localparam int DEPTH = 9 + 2 * MAX_REGS;
  localparam int BW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 2);
  localparam int GW = (TIMER_OUT > 2) ? $clog2(TIMER_OUT) : 1;
  localparam int IW = $clog2(MAX_REGS + 1);
  localparam logic [15:0] MAXQ = 16'(MAX_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_CHECK, S_WRITE, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_buf [DEPTH];
  logic [15:0]       r_crc;
  logic [LW-1:0]     r_len;
  logic [GW-1:0]     r_gap;
  logic              r_ovf;
  logic [IW-1:0]     r_i, r_qty;
  logic              r_d10;
  logic [15:0]       r_start;
  logic              r_wr_en, r_done, r_crc_err, r_frame_err, r_busy;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;

  logic              w_wr_en, w_done, w_crc_err, w_frame_err;
  logic [15:0]       w_start, w_qty16, w_len10, w_addr16, w_word;
  logic              w_fc10, w_ok10, w_ok06, w_addr_ok, w_dsel;
  logic [IW-1:0]     w_isel;
  logic [BW-1:0]     w_idx, w_hi, w_bidx;
  logic              w_bwr;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c_in,
    input logic [7:0]  b
  );
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    w_start = {r_buf[2], r_buf[3]};
    w_qty16 = {r_buf[4], r_buf[5]};
    w_len10 = {w_qty16[14:0], 1'b0} + 16'd9;
    w_fc10  = (r_buf[1] == 8'h10);
    w_ok10  = w_fc10 && (w_qty16 != 16'd0) &&
              (w_qty16 <= MAXQ) &&
              ({8'h00, r_buf[6]} ==
               {w_qty16[14:0], 1'b0}) &&
              (16'(r_len) == w_len10) && !r_ovf;
    w_ok06  = (r_buf[1] == 8'h06) &&
              (r_len == LW'(8));
`ifdef MB_BROADCAST_EN
    w_addr_ok = (r_buf[0] == SLAVE_ADDR) ||
                (r_buf[0] == 8'h00);
`else
    w_addr_ok = (r_buf[0] == SLAVE_ADDR);
`endif
    // The first word is issued from CHECK itself so the
    // registered wr_en lands one edge after CHECK.
    w_isel = (r_state == S_CHECK) ? '0 : r_i;
    w_dsel = (r_state == S_CHECK) ? w_fc10 : r_d10;
    w_idx  = (w_dsel ? BW'(7) : BW'(4)) +
             BW'({w_isel, 1'b0});
    w_hi   = (w_idx < BW'(DEPTH - 1)) ? w_idx : '0;
    w_word = {r_buf[w_hi], r_buf[w_hi + BW'(1)]};
    w_addr16 = ((r_state == S_CHECK) ? w_start : r_start) +
               16'(w_isel);
    w_bwr  = bus.rx_valid &&
             ((r_state == S_IDLE) ||
              ((r_state == S_RECV) &&
               (r_len < LW'(DEPTH))));
    w_bidx = (r_state == S_IDLE) ? '0 : r_len[BW-1:0];
  end

  always_comb begin
    w_next      = r_state;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    w_crc_err   = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (bus.rx_valid) w_next = S_RECV;
      S_RECV:
        if (!bus.rx_valid &&
            (r_gap == GW'(TIMER_OUT - 1)))
          w_next = S_CHECK;
      S_CHECK: begin
        w_next = S_IDLE;
        if (r_len < LW'(4)) begin
          w_next = S_IDLE;
        end else if (r_crc != 16'h0000) begin
          w_crc_err = 1'b1;
        end else if (!w_addr_ok) begin
          w_next = S_IDLE;
        end else if (w_ok10 || w_ok06) begin
          w_next  = S_WRITE;
          w_wr_en = 1'b1;
        end else begin
          w_frame_err = 1'b1;
        end
      end
      S_WRITE:
        if (r_i == r_qty) begin
          w_done = 1'b1;
          w_next = S_DONE;
        end else begin
          w_wr_en = 1'b1;
        end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_bwr) r_buf[w_bidx] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crc       <= 16'hFFFF;
      r_len       <= '0;
      r_gap       <= '0;
      r_ovf       <= 1'b0;
      r_i         <= '0;
      r_qty       <= '0;
      r_d10       <= 1'b0;
      r_start     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wr_en     <= w_wr_en;
      r_done      <= w_done;
      r_crc_err   <= w_crc_err;
      r_frame_err <= w_frame_err;
      r_busy      <= (w_next != S_IDLE);
      if (w_wr_en) begin
        r_wr_addr <= w_addr16[ADDR_W-1:0];
        r_wr_data <= w_word;
        r_i       <= w_isel + IW'(1);
      end
      if (r_state == S_CHECK) begin
        r_start <= w_start;
        r_d10   <= w_fc10;
        r_qty   <= w_fc10 ? w_qty16[IW-1:0] : IW'(1);
      end
      if ((r_state == S_IDLE) && bus.rx_valid) begin
        r_crc <= crc_upd(16'hFFFF, bus.rx_data);
        r_len <= LW'(1);
        r_gap <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == S_RECV) begin
        if (bus.rx_valid) begin
          if (r_len >= LW'(DEPTH)) r_ovf <= 1'b1;
          if (r_len < LW'(DEPTH + 1))
            r_len <= r_len + LW'(1);
          r_crc <= crc_upd(r_crc, bus.rx_data);
          r_gap <= '0;
        end else begin
          r_gap <= r_gap + GW'(1);
        end
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_done;
  assign bus.crc_err    = r_crc_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;
endmodule

// File: doc/mb_rtu_frame.md
# mb_rtu_frame

Parametrised Modbus RTU slave frame engine. Takes received bytes from the UART receiver and delimits frames by an inter-byte silence timer. It checks the CRC-16, slave address and frame structure, then replays write requests (function 0x10 multi-register, 0x06 single-register) as a one-register-per-cycle write stream into the register file. It sits between `uart_rx` and the application register bank, and supersedes the fixed-function `mb_rtu` receiver.

## Interface
Parameters:
- SLAVE_ADDR, 8'h01, station address this slave answers to
- TIMER_OUT, 10000, idle clk cycles after the last byte that end a frame (3.5 character times)
- MAX_REGS, 8, maximum registers per 0x10 frame; buffer depth is 9+2*MAX_REGS bytes
- ADDR_W, 16, width of wr_addr, range 1..16; start address truncated to ADDR_W LSBs

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- wr_en  out  1  register write strobe
- wr_addr  out  ADDR_W  register address
- wr_data  out  16  register value, high byte first on the wire
- frame_done  out  1  one-cycle pulse after the last write of an accepted frame
- crc_err  out  1  one-cycle pulse, CRC residue non-zero
- frame_err  out  1  one-cycle pulse, CRC good and address matched but structure/function invalid or buffer overflow
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RECV, CHECK, WRITE, DONE.
- IDLE: on rx_valid, store byte at index 0, CRC := update(0xFFFF, byte), len := 1, gap counter := 0, go to RECV.
- RECV:
  - On rx_valid: store byte at index len if len < buffer depth, else set ovf.
  - CRC is updated with every byte, including overflowed ones; len saturates at depth+1; gap counter := 0.
  - Otherwise the gap counter increments. When it equals TIMER_OUT-1 and no rx_valid is present, go to CHECK.
- CRC: Modbus CRC-16, reflected poly 0xA001, init 0xFFFF, byte-serial. The frame is good when the running CRC over all bytes, including the two trailing CRC bytes, equals 0x0000.
- CHECK (one cycle), evaluated in this order:
  1. len < 4 → silent drop to IDLE.
  2. CRC non-zero → crc_err, go to IDLE.
  3. Address ≠ SLAVE_ADDR (subject to the Configuration rule) → silent drop.
  4. Function 0x10 is accepted only if all hold: qty = {b4,b5} in 1..MAX_REGS, b6 = 2*qty, len = 9+2*qty, and no ovf.
  5. Function 0x06 is accepted only if len = 8; qty := 1, data starts at b4.
  6. Any other case → frame_err, go to IDLE.
  7. Accepted → WRITE, i := 0.
- WRITE: each cycle issue wr_en = 1 with:
  - wr_addr = ({b2,b3} + i) mod 2^ADDR_W (wraps, never saturates)
  - wr_data = {b[d+2i], b[d+2i+1]}, where d = 7 for 0x10 and d = 4 for 0x06
  - after i = qty-1, go to DONE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- rx_valid in CHECK, WRITE or DONE is discarded. Bytes only start a new frame from IDLE.
- Reset mid-frame or mid-WRITE: the state returns to IDLE immediately and the partial frame is lost. No further wr_en is issued.

## Timing
- All outputs are registered. Reset values: wr_en 0, wr_addr 0, wr_data 0, frame_done 0, crc_err 0, frame_err 0, busy 0.
- Last rx_valid sampled at edge k → CHECK at edge k+TIMER_OUT → first wr_en high after edge k+TIMER_OUT+1.
- wr_en is asserted for qty consecutive cycles. frame_done follows the last wr_en by one cycle.
- crc_err and frame_err assert in the cycle after CHECK and are mutually exclusive per frame.
- A new byte arriving on the same edge as gap counter = TIMER_OUT-1: the byte wins, the counter clears and the frame continues.
- busy rises the cycle after the first rx_valid and falls the cycle after DONE or a drop.

## Configuration
- MB_BROADCAST_EN defined: address 0x00 is accepted as broadcast, and writes execute identically to an addressed frame.
- MB_BROADCAST_EN undefined: address 0x00 is treated as a mismatch and silently dropped.

## Test plan
- FC06 frame 01 06 00 01 00 03 98 0B, then idle → single wr_en with wr_addr 0x0001, wr_data 0x0003; frame_done one cycle later; no error pulses.
- FC10 frame 01 10 00 00 00 02 04 41 30 00 00 + CRC from bench model → wr_en for 2 cycles: (0x0000, 0x4130), (0x0001, 0x0000); first wr_en TIMER_OUT+1 cycles after the last byte.
- Same FC06 frame with the last byte corrupted to 0x0C → crc_err pulse, no wr_en, busy falls.
- FC10 with qty = MAX_REGS+1 (valid CRC) → frame_err, no wr_en. FC10 start 0xFFFF, qty 2 with ADDR_W = 16 → wr_addr 0xFFFF then 0x0000.
- Frame to address 0x00 with valid CRC → writes only when built with MB_BROADCAST_EN, silent drop otherwise. Frame to address 0x02 → silent drop in both builds.
- rst asserted during the second wr_en of a 4-register write → wr_en low the next cycle, busy 0, no frame_done. A following valid frame is processed normally.
